// File: rtl/aidan_mcnay_div_unit_pkg.sv
// Shared definitions for the iterative divider: the default operand width
// and the rule that sizes the step counter.
package aidan_mcnay_div_unit_pkg;

    localparam int DIV_NBITS_DEFAULT = 16;

    // Counter must be able to hold the value nbits itself.
    function automatic int div_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/aidan_mcnay_div_step.sv
// One restoring shift-subtract step: shifts {R,Q} left by one, then
// subtracts the divisor from R and sets Q[0] when the shifted R covers it.
module aidan_mcnay_div_step
    import aidan_mcnay_div_unit_pkg::*;
#(
    parameter int nbits = DIV_NBITS_DEFAULT
) (
    input  logic [nbits:0]   rem,
    input  logic [nbits-1:0] quot,
    input  logic [nbits-1:0] divisor,
    output logic [nbits:0]   next_rem,
    output logic [nbits-1:0] next_quot
);

    logic [2*nbits:0] shifted;
    logic [nbits:0]   shifted_rem;
    logic             fits;

    // R is one bit wider than the divisor so the compare never overflows.
    always_comb begin
        shifted     = {rem, quot} << 1;
        shifted_rem = shifted[2*nbits:nbits];
        fits        = (shifted_rem >= {1'b0, divisor});
        next_rem    = fits ? (shifted_rem - {1'b0, divisor}) : shifted_rem;
        next_quot   = shifted[nbits-1:0] | {{(nbits-1){1'b0}}, fits};
    end

endmodule

// File: rtl/aidan_mcnay_div_unit.sv
// Iterative unsigned divider with val/rdy streams. One quotient bit is
// produced per cycle, so latency is fixed at nbits cycles of CALC for any
// operands, divide-by-zero included.
`ifndef SRC_DIV_UNIT
`define SRC_DIV_UNIT

module aidan_mcnay_div_unit
    import aidan_mcnay_div_unit_pkg::*;
#(
    parameter int nbits = DIV_NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [nbits-1:0] istream_dividend,
    input  logic [nbits-1:0] istream_divisor,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [nbits-1:0] ostream_quotient,
    output logic [nbits-1:0] ostream_remainder
);

    localparam int CNT_W = div_cnt_width(nbits);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [nbits:0]   rem;
    logic [nbits-1:0] quot;
    logic [nbits-1:0] divisor;
    logic [nbits:0]   step_rem;
    logic [nbits-1:0] step_quot;
    logic             last_step;

    assign last_step = (count == CNT_W'(1));

    aidan_mcnay_div_step #(
        .nbits (nbits)
    ) step (
        .rem       (rem),
        .quot      (quot),
        .divisor   (divisor),
        .next_rem  (step_rem),
        .next_quot (step_quot)
    );

    // Control FSM: accept in IDLE, iterate in CALC, hold result in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (istream_val) state <= CALC;
                CALC:    if (last_step)   state <= DONE;
                DONE:    if (ostream_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand load on input transfer, then one shift-subtract step per CALC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            quot  <= '0;
            rem   <= '0;
            count <= '0;
        end else if (state == IDLE && istream_val) begin
            quot    <= istream_dividend;
            rem     <= '0;
            divisor <= istream_divisor;
            count   <= CNT_W'(nbits);
        end else if (state == CALC) begin
            quot  <= step_quot;
            rem   <= step_rem;
            count <= count - CNT_W'(1);
        end
    end

    // Handshakes decode from state only; results come straight from registers.
    always_comb begin
        istream_rdy       = (state == IDLE);
        ostream_val       = (state == DONE);
        ostream_quotient  = quot;
        ostream_remainder = rem[nbits-1:0];
    end

endmodule

`endif

// File: tb/tb_aidan_mcnay_div_unit.sv
// Self-checking bench for aidan_mcnay_div_unit: directed cases, reset
// behaviour, backpressure and randomized traffic against a plain-arithmetic
// reference model.
module tb_aidan_mcnay_div_unit;

    localparam int NBITS = 16;
    localparam int LAT   = NBITS + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             istream_val = 1'b0;
    logic             istream_rdy;
    logic [NBITS-1:0] istream_dividend = '0;
    logic [NBITS-1:0] istream_divisor = '0;
    logic             ostream_val;
    logic             ostream_rdy = 1'b0;
    logic [NBITS-1:0] ostream_quotient;
    logic [NBITS-1:0] ostream_remainder;

    int passes = 0;
    int total  = 0;

    aidan_mcnay_div_unit #(
        .nbits (NBITS)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .istream_val       (istream_val),
        .istream_rdy       (istream_rdy),
        .istream_dividend  (istream_dividend),
        .istream_divisor   (istream_divisor),
        .ostream_val       (ostream_val),
        .ostream_rdy       (ostream_rdy),
        .ostream_quotient  (ostream_quotient),
        .ostream_remainder (ostream_remainder)
    );

    always #5 clk = ~clk;

    // Reference: ordinary division; divisor 0 gives all ones and the dividend.
    function automatic void model(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                                  output logic [NBITS-1:0] q, output logic [NBITS-1:0] r);
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issue one request and wait (bounded) for the result; lat counts cycles
    // from the transfer edge to the first cycle with ostream_val high.
    task automatic run_op(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                          output logic [NBITS-1:0] q, output logic [NBITS-1:0] r,
                          output int lat, output bit ok);
        int w;
        w  = 0;
        ok = 1'b1;
        while (!istream_rdy && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!istream_rdy) ok = 1'b0;
        istream_dividend = a;
        istream_divisor  = b;
        istream_val      = 1'b1;
        @(posedge clk); #1;
        istream_val = 1'b0;
        lat = 1;
        while (!ostream_val && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ostream_val) ok = 1'b0;
        q = ostream_quotient;
        r = ostream_remainder;
    endtask

    task automatic accept();
        ostream_rdy = 1'b1;
        @(posedge clk); #1;
        ostream_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        istream_val = 1'b1;
        istream_dividend = 16'd77;
        istream_divisor  = 16'd7;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({istream_rdy, ostream_val} !== 2'b10) $display("FAIL reset_hs: got rdy=%0b val=%0b expected rdy=1 val=0", istream_rdy, ostream_val);
        else passes++;
        total++;
        if ({ostream_quotient, ostream_remainder} !== 32'd0) $display("FAIL reset_data: got q=%0d r=%0d expected q=0 r=0", ostream_quotient, ostream_remainder);
        else passes++;
        istream_val = 1'b0;
        reset       = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({istream_rdy, ostream_val} !== 2'b10) $display("FAIL reset_release: got rdy=%0b val=%0b expected rdy=1 val=0", istream_rdy, ostream_val);
        else passes++;
    endtask

    task automatic test_basic();
        logic [NBITS-1:0] q, r;
        int lat;
        bit ok;
        run_op(16'd100, 16'd7, q, r, lat, ok);
        total++;
        if (!ok || lat != LAT) $display("FAIL basic_latency: got %0d cycles (ok=%0b) expected %0d", lat, ok, LAT);
        else passes++;
        total++;
        if (q !== 16'd14 || r !== 16'd2) $display("FAIL basic_result: got q=%0d r=%0d expected q=14 r=2", q, r);
        else passes++;
        accept();
        total++;
        if ({istream_rdy, ostream_val} !== 2'b10) $display("FAIL basic_return_idle: got rdy=%0b val=%0b expected rdy=1 val=0", istream_rdy, ostream_val);
        else passes++;
    endtask

    task automatic test_boundaries();
        logic [NBITS-1:0] as [5] = '{16'd7, 16'd3, 16'hFFFF, 16'hFFFF, 16'd5};
        logic [NBITS-1:0] bs [5] = '{16'd7, 16'd5, 16'd1, 16'hFFFF, 16'd0};
        logic [NBITS-1:0] q, r, eq, er;
        int lat;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            model(as[i], bs[i], eq, er);
            run_op(as[i], bs[i], q, r, lat, ok);
            total++;
            if (!ok || lat != LAT) $display("FAIL boundary_latency %0d/%0d: got %0d cycles expected %0d", as[i], bs[i], lat, LAT);
            else passes++;
            total++;
            if (q !== eq || r !== er) $display("FAIL boundary_result %0d/%0d: got q=%0d r=%0d expected q=%0d r=%0d", as[i], bs[i], q, r, eq, er);
            else passes++;
            accept();
        end
    endtask

    task automatic test_backpressure();
        logic [NBITS-1:0] q, r;
        int lat;
        bit ok;
        int bad;
        run_op(16'd1000, 16'd33, q, r, lat, ok);
        total++;
        if (!ok || q !== 16'd30 || r !== 16'd10) $display("FAIL bp_result: got q=%0d r=%0d ok=%0b expected q=30 r=10", q, r, ok);
        else passes++;
        istream_dividend = 16'd50;
        istream_divisor  = 16'd5;
        istream_val      = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if ({ostream_val, istream_rdy, ostream_quotient, ostream_remainder} !== {2'b10, 16'd30, 16'd10}) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        else passes++;
        istream_val = 1'b0;
        accept();
        total++;
        if ({istream_rdy, ostream_val} !== 2'b10) $display("FAIL bp_release: got rdy=%0b val=%0b expected rdy=1 val=0", istream_rdy, ostream_val);
        else passes++;
        total++;
        if (ostream_quotient !== 16'd30 || ostream_remainder !== 16'd10) $display("FAIL bp_keep_last: got q=%0d r=%0d expected q=30 r=10", ostream_quotient, ostream_remainder);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [NBITS-1:0] q, r;
        int lat;
        bit ok;
        int spurious;
        istream_dividend = 16'd500;
        istream_divisor  = 16'd9;
        istream_val      = 1'b1;
        @(posedge clk); #1;
        istream_val = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if ({istream_rdy, ostream_val} !== 2'b10 || ostream_quotient !== 16'd0 || ostream_remainder !== 16'd0)
            $display("FAIL mid_reset_state: got rdy=%0b val=%0b q=%0d r=%0d expected rdy=1 val=0 q=0 r=0",
                     istream_rdy, ostream_val, ostream_quotient, ostream_remainder);
        else passes++;
        spurious = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (ostream_val) spurious++;
        end
        total++;
        if (spurious != 0) $display("FAIL mid_reset_no_result: got %0d valid cycles expected 0", spurious);
        else passes++;
        run_op(16'd9, 16'd3, q, r, lat, ok);
        total++;
        if (!ok || q !== 16'd3 || r !== 16'd0) $display("FAIL mid_reset_next: got q=%0d r=%0d ok=%0b expected q=3 r=0", q, r, ok);
        else passes++;
        accept();
    endtask

    task automatic test_prime_sequence();
        logic [NBITS-1:0] exp_rem [$];
        logic [NBITS-1:0] q, r, eq, er, got_r;
        int lat;
        bit ok;
        int bad, dup, outs;
        bad  = 0;
        dup  = 0;
        outs = 0;
        for (int d = 2; d <= 13; d++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            model(16'd13, NBITS'(d), eq, er);
            exp_rem.push_back(er);
            run_op(16'd13, NBITS'(d), q, r, lat, ok);
            if (!ok) bad++;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                if (!ostream_val || ostream_remainder !== r) bad++;
            end
            accept();
            outs++;
            if (ostream_val) dup++;
            got_r = exp_rem.pop_front();
            total++;
            if (r !== got_r) $display("FAIL prime_rem 13/%0d: got %0d expected %0d", d, r, got_r);
            else passes++;
        end
        total++;
        if (bad != 0 || dup != 0 || outs != 12 || exp_rem.size() != 0)
            $display("FAIL prime_stream: got bad=%0d dup=%0d outs=%0d left=%0d expected 0/0/12/0", bad, dup, outs, exp_rem.size());
        else passes++;
    endtask

    task automatic test_random();
        logic [NBITS-1:0] a, b, q, r, eq, er;
        int lat;
        bit ok;
        for (int i = 0; i < 20; i++) begin
            a = NBITS'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = NBITS'($urandom_range(1, 15));
                2:       b = a + NBITS'($urandom_range(0, 3));
                default: b = NBITS'($urandom);
            endcase
            model(a, b, eq, er);
            run_op(a, b, q, r, lat, ok);
            total++;
            if (!ok || lat != LAT || q !== eq || r !== er)
                $display("FAIL random %0d/%0d: got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=%0d", a, b, q, r, lat, eq, er, LAT);
            else passes++;
            accept();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_reset_mid();
        test_prime_sequence();
        test_random();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
